eth_fcs_checker: RTL and testbench

Receive-side counterpart of the frame generator's CRC-32 path. Accepts a byte stream starting at destination MAC and ending at the last FCS byte, preamble and SFD already removed. Recomputes IEEE 802.3 CRC-32 on the fly, checks the residue, and validates frame length. Forwards the frame downstream, optionally with the 4 FCS bytes stripped, and keeps good/bad frame counters.

---
 rtl/eth_pkg.sv | 21 ++
 rtl/crc32_next_byte.sv | 21 ++
 rtl/eth_fcs_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_fcs_checker.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet CRC-32 constants, legal frame length limits and the
// receive FSM state type used by the FCS checker and the frame generator.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    localparam int ETH_MIN_LEN = 64;
    localparam int ETH_MAX_LEN = 1518;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/crc32_next_byte.sv
// Combinational one-byte update of the reflected IEEE 802.3 CRC-32 register,
// data consumed LSB first. Shared by the transmit and receive CRC paths.
module crc32_next_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_work;

    always_comb begin
        crc_work = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC32_POLY_REFL) : (crc_work >> 1);
        end
        crc_out = crc_work;
    end

endmodule

// File: rtl/eth_fcs_checker.sv
// Receive-side Ethernet FCS and length checker with frame forwarding and
// good/bad counters. Define ETH_FCS_STRIP_EN to remove the FCS from the output.
module eth_fcs_checker
    import eth_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic        frame_abort,
    output logic [11:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [11:0] MIN_LEN_W = 12'(MIN_LEN);
    localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

    function automatic logic len_bad(input logic [11:0] n);
        return (n < MIN_LEN_W) || (n > MAX_LEN_W);
    endfunction

    rx_state_t   state_q, state_d;
    logic [31:0] crc_q, crc_d, crc_base, crc_upd;
    logic [11:0] cnt_q, cnt_d, cnt_base, cnt_upd;
    logic        done_q, done_d;
    logic        fcs_ok_q, fcs_ok_d;
    logic        len_err_q, len_err_d;
    logic        abort_q, abort_d;
    logic [11:0] len_q, len_d;
    logic [15:0] good_q, good_d;
    logic [15:0] bad_q, bad_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;

    logic accept;
    logic aborting;
    logic finish;
    logic frame_good;

    // A start-of-frame byte always restarts the CRC and count from scratch.
    assign accept   = rx_valid && (state_q == RECV || rx_sof);
    assign aborting = rx_valid && rx_sof && (state_q == RECV);
    assign crc_base = rx_sof ? CRC32_INIT : crc_q;
    assign cnt_base = rx_sof ? 12'd0 : cnt_q;
    assign cnt_upd  = (cnt_base == 12'hFFF) ? cnt_base : cnt_base + 12'd1;

    crc32_next_byte u_crc (
        .crc_in  (crc_base),
        .data    (rx_data),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        fcs_ok_d   = fcs_ok_q;
        len_err_d  = len_err_q;
        abort_d    = abort_q;
        len_d      = len_q;
        good_d     = good_q;
        bad_d      = bad_q;
        finish     = 1'b0;
        frame_good = 1'b0;

        if (aborting) begin
            finish    = 1'b1;
            done_d    = 1'b1;
            abort_d   = 1'b1;
            fcs_ok_d  = 1'b0;
            len_err_d = len_bad(cnt_q);
            len_d     = cnt_q;
        end else if (accept && rx_eof) begin
            finish     = 1'b1;
            done_d     = 1'b1;
            abort_d    = 1'b0;
            // rx_sof here means a single-byte frame, never a valid FCS
            fcs_ok_d   = !rx_sof && (crc_upd == CRC32_RESIDUE);
            len_err_d  = len_bad(cnt_upd);
            len_d      = cnt_upd;
            frame_good = fcs_ok_d && !len_err_d;
        end

        if (finish) begin
            if (frame_good) begin
                good_d = sat_inc16(good_q);
            end else begin
                bad_d = sat_inc16(bad_q);
            end
        end

        if (accept) begin
            if (rx_eof) begin
                state_d = IDLE;
                crc_d   = CRC32_INIT;
                cnt_d   = 12'd0;
            end else begin
                state_d = RECV;
                crc_d   = crc_upd;
                cnt_d   = cnt_upd;
            end
        end
    end

`ifdef ETH_FCS_STRIP_EN
    logic [31:0] dl_q, dl_d;
    logic [2:0]  fill_q, fill_d;
    logic        sof_pend_q, sof_pend_d;

    // dl_q[31:24] is the oldest byte; it leaves only once four newer bytes exist.
    always_comb begin
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        out_data_d  = out_data_q;
        dl_d        = dl_q;
        fill_d      = fill_q;
        sof_pend_d  = sof_pend_q;

        if (accept) begin
            dl_d = {dl_q[23:0], rx_data};
            if (rx_sof) begin
                fill_d     = 3'd1;
                sof_pend_d = 1'b1;
            end else if (fill_q == 3'd4) begin
                out_valid_d = 1'b1;
                out_data_d  = dl_q[31:24];
                out_sof_d   = sof_pend_q;
                out_eof_d   = rx_eof;
                sof_pend_d  = 1'b0;
            end else begin
                fill_d = fill_q + 3'd1;
            end
            if (rx_eof) begin
                fill_d     = 3'd0;
                sof_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_q       <= '0;
            fill_q     <= '0;
            sof_pend_q <= 1'b0;
        end else begin
            dl_q       <= dl_d;
            fill_q     <= fill_d;
            sof_pend_q <= sof_pend_d;
        end
    end
`else
    always_comb begin
        out_valid_d = accept;
        out_data_d  = accept ? rx_data : out_data_q;
        out_sof_d   = accept && rx_sof;
        out_eof_d   = accept && rx_eof;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= CRC32_INIT;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            fcs_ok_q    <= 1'b0;
            len_err_q   <= 1'b0;
            abort_q     <= 1'b0;
            len_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            fcs_ok_q    <= fcs_ok_d;
            len_err_q   <= len_err_d;
            abort_q     <= abort_d;
            len_q       <= len_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_eof     = out_eof_q;
    assign frame_done  = done_q;
    assign fcs_ok      = fcs_ok_q;
    assign len_err     = len_err_q;
    assign frame_abort = abort_q;
    assign frame_len   = len_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;

endmodule

// File: tb/tb_eth_fcs_checker.sv
// Randomized self-checking bench for eth_fcs_checker: frames are checked against
// a frame-level model (whole-frame CRC compare, length rules, expected byte list).
module tb_eth_fcs_checker;

`ifdef ETH_FCS_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif

    typedef logic [7:0] byte_t;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        int         cyc;
    } obyte_t;

    typedef struct {
        logic        fcs_ok;
        logic        len_err;
        logic        abort;
        logic [11:0] len;
        logic [15:0] good;
        logic [15:0] bad;
        int          cyc;
    } done_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof;
    logic [7:0]  out_data;
    logic        out_valid, out_sof, out_eof;
    logic        frame_done, fcs_ok, len_err, frame_abort;
    logic [11:0] frame_len;
    logic [15:0] good_cnt, bad_cnt;

    eth_fcs_checker #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .fcs_ok      (fcs_ok),
        .len_err     (len_err),
        .frame_abort (frame_abort),
        .frame_len   (frame_len),
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int good_m   = 0;
    int bad_m    = 0;

    byte_t  frm[$];
    obyte_t out_q[$];
    done_t  done_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        obyte_t o;
        done_t  d;
        if (!rst) begin
            if (out_valid) begin
                o.d = out_data; o.sof = out_sof; o.eof = out_eof; o.cyc = cyc;
                out_q.push_back(o);
            end
            if (frame_done) begin
                d.fcs_ok = fcs_ok; d.len_err = len_err; d.abort = frame_abort;
                d.len = frame_len; d.good = good_cnt; d.bad = bad_cnt; d.cyc = cyc;
                done_q.push_back(d);
            end
        end
    end

    // Bit-serial CRC-32 over the first n bytes, final complement applied.
    function automatic logic [31:0] crc32_of(input byte_t f[$], input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ f[i][b];
                c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic bit model_fcs_ok(input byte_t f[$]);
        int n;
        n = f.size();
        if (n < 5) return 1'b0;
        return crc32_of(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]};
    endfunction

    task automatic append_fcs();
        logic [31:0] fcs;
        fcs = crc32_of(frm, frm.size());
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic build_rand(input int n_payload);
        frm.delete();
        for (int i = 0; i < n_payload; i++) frm.push_back(8'($urandom));
        append_fcs();
    endtask

    task automatic build_std();
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
        for (int i = 0; i < 6; i++) frm.push_back(8'(i * 17));
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 0; i < 46; i++) frm.push_back(8'h00);
        append_fcs();
    endtask

    task automatic idle_inputs();
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_frame(input bit with_eof, input int gap_pct, input int n_limit,
                              output int first_cyc, output int last_cyc);
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < n_limit; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                rx_sof   = 1'($urandom);
                rx_eof   = 1'($urandom);
            end
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = frm[i];
            rx_sof   = (i == 0);
            rx_eof   = with_eof && (i == frm.size() - 1);
            if (i == 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic stray_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_sof   = 1'b0;
            rx_eof   = 1'($urandom);
            rx_data  = 8'($urandom);
        end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        check_val("stray.out_count", out_q.size(), 0);
        check_val("stray.done_count", done_q.size(), 0);
        out_q.delete();
        done_q.delete();
    endtask

    task automatic expect_done(input string tag, input int exp_len, input bit exp_fcs,
                               input bit exp_lerr, input bit exp_abort, input int exp_cyc);
        done_t d;
        check_val({tag, ".done_seen"}, 32'(done_q.size() > 0), 1);
        if (done_q.size() == 0) return;
        d = done_q.pop_front();
        if (exp_fcs && !exp_lerr && !exp_abort) good_m++;
        else bad_m++;
        check_val({tag, ".fcs_ok"}, d.fcs_ok, exp_fcs);
        check_val({tag, ".len_err"}, d.len_err, exp_lerr);
        check_val({tag, ".abort"}, d.abort, exp_abort);
        check_val({tag, ".frame_len"}, d.len, (exp_len > 4095) ? 4095 : exp_len);
        check_val({tag, ".good_cnt"}, d.good, good_m);
        check_val({tag, ".bad_cnt"}, d.bad, bad_m);
        check_val({tag, ".done_latency"}, d.cyc, exp_cyc);
    endtask

    task automatic expect_out(input string tag, input int n_sent, input bit full, input int done_cyc);
        int exp_n, n_cmp, bad_data, bad_sof, bad_eof;
        exp_n = STRIP ? ((n_sent > 4) ? n_sent - 4 : 0) : n_sent;
        n_cmp = (out_q.size() < exp_n) ? out_q.size() : exp_n;
        bad_data = 0; bad_sof = 0; bad_eof = 0;
        check_val({tag, ".out_count"}, out_q.size(), exp_n);
        for (int i = 0; i < n_cmp; i++) begin
            if (out_q[i].d !== frm[i]) bad_data++;
            if (out_q[i].sof !== (i == 0)) bad_sof++;
            if (out_q[i].eof !== (full && i == exp_n - 1)) bad_eof++;
        end
        check_val({tag, ".out_data_errs"}, bad_data, 0);
        check_val({tag, ".out_sof_errs"}, bad_sof, 0);
        check_val({tag, ".out_eof_errs"}, bad_eof, 0);
        if (full && exp_n > 0 && out_q.size() >= exp_n)
            check_val({tag, ".out_eof_cycle"}, out_q[exp_n-1].cyc, done_cyc);
        out_q.delete();
    endtask

    task automatic run_frame(input string tag, input int gap_pct);
        int f_cyc, l_cyc, n;
        n = frm.size();
        send_frame(1'b1, gap_pct, n, f_cyc, l_cyc);
        repeat (3) @(negedge clk);
        expect_done(tag, n, model_fcs_ok(frm), (n < 64) || (n > 1518), 1'b0, l_cyc + 1);
        expect_out(tag, n, 1'b1, l_cyc + 1);
        check_val({tag, ".extra_done"}, done_q.size(), 0);
        done_q.delete();
    endtask

    initial begin : main
        int f_cyc, l_cyc, len;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_val("reset.outputs", {out_data, out_valid, out_sof, out_eof, frame_done,
                                    fcs_ok, len_err, frame_abort}, 0);
        check_val("reset.frame_len", frame_len, 0);
        check_val("reset.counters", {good_cnt, bad_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        stray_bytes(3);

        frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                8'h26, 8'h39, 8'hF4, 8'hCB};
        run_frame("check_string", 0);

        build_std();
        run_frame("min_good", 0);

        build_std();
        frm[20][0] = ~frm[20][0];
        run_frame("bit_flip", 0);

        build_rand(1515);
        run_frame("len_1519", 0);
        build_rand(1514);
        run_frame("len_1518", 0);
        build_rand(59);
        run_frame("len_63", 0);

        frm.delete();
        frm.push_back(8'($urandom));
        run_frame("one_byte", 0);

        // 30 bytes with no end, then a new frame's start aborts them
        frm.delete();
        for (int i = 0; i < 30; i++) frm.push_back(8'($urandom));
        send_frame(1'b0, 0, 30, f_cyc, l_cyc);
        repeat (3) @(negedge clk);
        expect_out("abort_part", 30, 1'b0, 0);
        check_val("abort_part.no_done", done_q.size(), 0);
        build_std();
        send_frame(1'b1, 0, frm.size(), f_cyc, l_cyc);
        repeat (3) @(negedge clk);
        expect_done("abort", 30, 1'b0, 1'b1, 1'b1, f_cyc + 1);
        expect_done("after_abort", 64, model_fcs_ok(frm), 1'b0, 1'b0, l_cyc + 1);
        expect_out("after_abort", 64, 1'b1, l_cyc + 1);

        build_std();
        run_frame("min_good_gaps", 40);

        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(5, 160));
            build_rand(len - 4);
            if ($urandom_range(2) == 0) begin
                int bi;
                bi = int'($urandom_range(len - 1));
                frm[bi] = frm[bi] ^ (8'd1 << $urandom_range(7));
            end
            run_frame($sformatf("rand%0d", it), ($urandom_range(1) == 1) ? 35 : 0);
            if ($urandom_range(3) == 0) stray_bytes(int'($urandom_range(1, 3)));
        end

        // reset in the middle of a frame discards it and clears the counters
        build_std();
        send_frame(1'b0, 0, 40, f_cyc, l_cyc);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("midrst.outputs", {out_data, out_valid, out_sof, out_eof, frame_done,
                                     fcs_ok, len_err, frame_abort}, 0);
        check_val("midrst.frame_len", frame_len, 0);
        check_val("midrst.counters", {good_cnt, bad_cnt}, 0);
        check_val("midrst.no_done", done_q.size(), 0);
        out_q.delete();
        done_q.delete();
        good_m = 0;
        bad_m  = 0;
        rst = 1'b0;
        @(negedge clk);
        build_std();
        run_frame("post_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
